// File: rtl/axis_video_pkg.sv
// rtl/axis_video_pkg.sv - shared types and constants for the video stream FIFO
package axis_video_pkg;

  localparam int PIX_W      = 24;
  localparam int DROP_CNT_W = 16;

  typedef struct packed {
    logic [PIX_W-1:0] tdata;
    logic             tuser;
    logic             tlast;
  } beat_t;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    PASS     = 2'd1,
    DROP     = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/axis_video_fifo_ram.sv
// rtl/axis_video_fifo_ram.sv - simple dual-port beat store, registered read, no array reset
module axis_video_fifo_ram #(
  parameter int WIDTH   = 26,
  parameter int ENTRIES = 1023,
  parameter int AW      = 10
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_video_fifo.sv
// rtl/axis_video_fifo.sv - backpressure buffer with frame resync and line-length check
module axis_video_fifo
  import axis_video_pkg::*;
#(
  parameter int DATA_W = PIX_W,
  parameter int DEPTH  = 1024,
  parameter int H_RES  = 640
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       s_tdata,
  input  logic                    s_tvalid,
  input  logic                    s_tuser,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic [DATA_W-1:0]       m_tdata,
  output logic                    m_tvalid,
  output logic                    m_tuser,
  output logic                    m_tlast,
  input  logic                    m_tready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    in_sync,
  output logic                    overflow,
  output logic                    line_err,
  output logic [DROP_CNT_W-1:0]   drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int XW = $clog2(H_RES + 1);
  localparam int BW = DATA_W + 2;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 2);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [XW-1:0] LINE_END  = XW'(H_RES - 1);

  fifo_state_e state, state_nxt;
  logic has_space, accept, discard;

  logic [BW-1:0] in_beat, ram_q, fwd_beat, head_beat, out_beat;
  logic          out_valid, fwd_valid;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [LW-1:0] ram_cnt;
  logic          pop, ram_has, out_load, ram_rd, bypass, ram_wr;
  logic [XW-1:0] x_cnt, x_pos;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + 1'b1;
  endfunction

  assign has_space = level < FULL_LVL;
  assign s_tready  = has_space;
  assign in_sync   = (state == PASS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= WAIT_SOF;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_SOF: if (s_tvalid && s_tuser && has_space) state_nxt = PASS;
      PASS:     if (s_tvalid && !has_space)           state_nxt = DROP;
      DROP:     if (s_tvalid && s_tuser && has_space) state_nxt = PASS;
      default:  state_nxt = WAIT_SOF;
    endcase
  end

  // Beats rejected while searching for the first SOF are not counted as drops.
  always_comb begin
    accept  = 1'b0;
    discard = 1'b0;
    unique case (state)
      WAIT_SOF: accept = s_tvalid && s_tuser && has_space;
      PASS: begin
        accept  = s_tvalid && has_space;
        discard = s_tvalid && !has_space;
      end
      DROP: begin
        accept  = s_tvalid && s_tuser && has_space;
        discard = s_tvalid && !(s_tuser && has_space);
      end
      default: ;
    endcase
  end

  // The output register is never empty while the RAM holds beats, so level>0 implies m_tvalid.
  assign in_beat  = {s_tdata, s_tuser, s_tlast};
  assign pop      = out_valid && m_tready;
  assign ram_cnt  = level - LW'(out_valid);
  assign ram_has  = (ram_cnt != '0);
  assign out_load = (!out_valid || pop) && (ram_has || accept);
  assign ram_rd   = out_load && ram_has;
  assign bypass   = out_load && !ram_has;
  assign ram_wr   = accept && !bypass;

  assign rd_ptr_nxt = ram_rd ? ptr_inc(rd_ptr) : rd_ptr;
  // A write landing on the address being prefetched is not yet visible in ram_q.
  assign head_beat  = fwd_valid ? fwd_beat : ram_q;

  axis_video_fifo_ram #(
    .WIDTH   (BW),
    .ENTRIES (DEPTH - 1),
    .AW      (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr),
    .wr_addr (wr_ptr),
    .wr_data (in_beat),
    .rd_addr (rd_ptr_nxt),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_beat  <= '0;
      fwd_valid <= 1'b0;
      fwd_beat  <= '0;
    end else begin
      level     <= level + LW'(accept) - LW'(pop);
      rd_ptr    <= rd_ptr_nxt;
      fwd_valid <= ram_wr && (wr_ptr == rd_ptr_nxt);
      if (ram_wr) begin
        wr_ptr   <= ptr_inc(wr_ptr);
        fwd_beat <= in_beat;
      end
      if (out_load) begin
        out_valid <= 1'b1;
        out_beat  <= bypass ? in_beat : head_beat;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign m_tvalid = out_valid;
  assign m_tdata  = out_beat[BW-1:2];
  assign m_tuser  = out_beat[1];
  assign m_tlast  = out_beat[0];

  // A tuser beat sits at position 0, except that a tuser+tlast beat is judged on the old count.
  assign x_pos = s_tuser ? '0 : x_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_cnt      <= '0;
      line_err   <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (accept) begin
        if (s_tlast) begin
          if (x_cnt != LINE_END) line_err <= 1'b1;
          x_cnt <= '0;
        end else if (x_pos == LINE_END) begin
          line_err <= 1'b1;
          x_cnt    <= '0;
        end else begin
          x_cnt <= x_pos + 1'b1;
        end
      end else if (state != PASS) begin
        x_cnt <= '0;
      end
      if (discard && state == PASS) overflow <= 1'b1;
      if (discard && drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_video_fifo.sv
// tb/tb_axis_video_fifo.sv - randomized and directed checks against a queue-based reference
module tb_axis_video_fifo;
  import axis_video_pkg::*;

  localparam int DW    = 24;
  localparam int DEPTH = 16;
  localparam int H_RES = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tuser, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tuser, m_tlast, m_tready;
  logic [LW-1:0] level;
  logic          in_sync, overflow, line_err;
  logic [15:0]   drop_count;

  int total = 0;
  int bad   = 0;
  int hs    = 0;

  always #5 clk = ~clk;

  axis_video_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .H_RES(H_RES)) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tready(m_tready),
    .level(level), .in_sync(in_sync), .overflow(overflow), .line_err(line_err),
    .drop_count(drop_count)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: the buffer is a queue of accepted beats; the head is visible whenever it is non-empty.
  beat_t       q[$];
  fifo_state_e md    = WAIT_SOF;
  bit          ovf   = 1'b0;
  bit          lerr  = 1'b0;
  int          drops = 0;
  int          pos   = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      md    <= WAIT_SOF;
      ovf   <= 1'b0;
      lerr  <= 1'b0;
      drops <= 0;
      pos   <= 0;
    end else begin : step
      int    sz, p;
      bit    acc, pop;
      beat_t b;
      sz  = q.size();
      acc = s_tvalid && (sz < DEPTH) && (md == PASS || s_tuser);
      pop = (sz != 0) && m_tready;
      if (acc) md <= PASS;
      else if (s_tvalid && md != WAIT_SOF) begin
        if (drops < 65535) drops <= drops + 1;
        if (md == PASS) begin
          ovf <= 1'b1;
          md  <= DROP;
        end
      end
      if (acc) begin
        if (s_tlast) begin
          if (pos != H_RES - 1) lerr <= 1'b1;
          pos <= 0;
        end else begin
          p = s_tuser ? 0 : pos;
          if (p == H_RES - 1) begin
            lerr <= 1'b1;
            pos  <= 0;
          end else begin
            pos <= p + 1;
          end
        end
      end else if (md != PASS) begin
        pos <= 0;
      end
      if (pop) void'(q.pop_front());
      if (acc) begin
        b.tdata = s_tdata;
        b.tuser = s_tuser;
        b.tlast = s_tlast;
        q.push_back(b);
      end
    end
  end

  always @(negedge clk) begin
    chk("m_tvalid",   64'(m_tvalid),   64'(q.size() != 0));
    chk("level",      64'(level),      64'(q.size()));
    chk("s_tready",   64'(s_tready),   64'(q.size() < DEPTH));
    chk("in_sync",    64'(in_sync),    64'(md == PASS));
    chk("overflow",   64'(overflow),   64'(ovf));
    chk("line_err",   64'(line_err),   64'(lerr));
    chk("drop_count", 64'(drop_count), 64'(drops));
    if (q.size() != 0) begin
      chk("m_tdata", 64'(m_tdata), 64'(q[0].tdata));
      chk("m_tuser", 64'(m_tuser), 64'(q[0].tuser));
      chk("m_tlast", 64'(m_tlast), 64'(q[0].tlast));
    end
  end

  always @(posedge clk) if (m_tvalid && m_tready) hs <= hs + 1;

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom);
  endfunction

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit u, input bit l, input bit r);
    @(negedge clk);
    s_tvalid = v;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    m_tready = r;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, r);
  endtask

  task automatic send_frame(input int n, input bit r);
    for (int k = 0; k < n; k++) drive(1'b1, rnd(), k == 0, (k % H_RES) == H_RES - 1, r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int hs0, maxlvl;
    s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_s_tready", 64'(s_tready), 64'd1);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_level",    64'(level),    64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop",     64'(drop_count), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Leading beats without SOF vanish; then a frame streams through with one cycle of latency.
    for (int i = 0; i < 10; i++) drive(1'b1, rnd(), 1'b0, (i % H_RES) == H_RES - 1, 1'b1);
    idle(1, 1'b1);
    chk("t1_pre_level", 64'(level), 64'd0);
    chk("t1_pre_sync",  64'(in_sync), 64'd0);
    hs0 = hs;
    drive(1'b1, 24'hABCDEF, 1'b1, 1'b0, 1'b1);
    drive(1'b1, rnd(), 1'b0, 1'b0, 1'b1);
    chk("t1_sync",       64'(in_sync),  64'd1);
    chk("t1_first_vld",  64'(m_tvalid), 64'd1);
    chk("t1_first_user", 64'(m_tuser),  64'd1);
    chk("t1_first_data", 64'(m_tdata),  64'hABCDEF);
    for (int k = 2; k < 4 * H_RES; k++) drive(1'b1, rnd(), 1'b0, (k % H_RES) == H_RES - 1, 1'b1);
    idle(3, 1'b1);
    chk("t1_beats_out", 64'(hs - hs0), 64'd32);
    chk("t1_line_err",  64'(line_err), 64'd0);
    chk("t1_drops",     64'(drop_count), 64'd0);

    // Stalled sink: 16 beats fit, the remaining 14 of 30 are dropped.
    do_reset();
    send_frame(30, 1'b0);
    idle(1, 1'b0);
    chk("t2_level",    64'(level),      64'd16);
    chk("t2_overflow", 64'(overflow),   64'd1);
    chk("t2_sync",     64'(in_sync),    64'd0);
    chk("t2_drops",    64'(drop_count), 64'd14);
    drive(1'b1, rnd(), 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("t2_sof_full_drop", 64'(drop_count), 64'd15);
    idle(20, 1'b1);
    chk("t2_drained", 64'(level), 64'd0);
    drive(1'b1, 24'h123456, 1'b1, 1'b0, 1'b1);
    idle(1, 1'b1);
    chk("t2_resync",      64'(in_sync), 64'd1);
    chk("t2_resync_user", 64'(m_tuser), 64'd1);
    chk("t2_resync_data", 64'(m_tdata), 64'h123456);
    idle(3, 1'b1);

    // Half-rate source against a sink toggling every cycle.
    do_reset();
    hs0 = hs;
    maxlvl = 0;
    for (int i = 0; i < 200; i++) begin
      drive(i % 2 == 0, rnd(), i == 0, ((i / 2) % H_RES) == H_RES - 1, i % 2 == 1);
      if (int'(level) > maxlvl) maxlvl = int'(level);
    end
    idle(3, 1'b1);
    chk("t3_beats_out", 64'(hs - hs0), 64'd100);
    chk("t3_max_level", 64'(maxlvl <= 2), 64'd1);

    // A full line with no tlast flags on its last beat.
    do_reset();
    for (int k = 0; k < 7; k++) drive(1'b1, rnd(), k == 0, 1'b0, 1'b1);
    idle(1, 1'b1);
    chk("t4_no_err_yet", 64'(line_err), 64'd0);
    drive(1'b1, rnd(), 1'b0, 1'b0, 1'b1);
    idle(1, 1'b1);
    chk("t4_missing_tlast", 64'(line_err), 64'd1);
    // An early tlast flags too.
    do_reset();
    for (int k = 0; k < 4; k++) drive(1'b1, rnd(), k == 0, 1'b0, 1'b1);
    idle(1, 1'b1);
    chk("t4_short_pre", 64'(line_err), 64'd0);
    drive(1'b1, rnd(), 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);
    chk("t4_short_line", 64'(line_err), 64'd1);
    idle(3, 1'b1);

    // Push and pop together when full, then at a mid level.
    do_reset();
    send_frame(16, 1'b0);
    idle(1, 1'b0);
    chk("t5_full", 64'(level), 64'd16);
    drive(1'b1, rnd(), 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);
    chk("t5_full_pushpop", 64'(level),    64'd15);
    chk("t5_overflow",     64'(overflow), 64'd1);
    idle(10, 1'b1);
    drive(1'b1, rnd(), 1'b1, 1'b0, 1'b1);
    chk("t5_level5_pre", 64'(level), 64'd5);
    idle(1, 1'b0);
    chk("t5_level5_post", 64'(level),   64'd5);
    chk("t5_resync",      64'(in_sync), 64'd1);
    idle(8, 1'b1);

    // Reset during a stalled output beat withdraws it at once.
    do_reset();
    send_frame(4, 1'b0);
    idle(1, 1'b0);
    chk("t6_stalled", 64'(m_tvalid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_vld_gone", 64'(m_tvalid), 64'd0);
    chk("t6_level",    64'(level),    64'd0);
    chk("t6_sync",     64'(in_sync),  64'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, rnd(), 1'b0, 1'b0, 1'b1);
    idle(1, 1'b1);
    chk("t6_discard_level", 64'(level),      64'd0);
    chk("t6_discard_drops", 64'(drop_count), 64'd0);
    send_frame(8, 1'b1);
    idle(3, 1'b1);

    // Random traffic with shifting backpressure and occasional bad tlast.
    do_reset();
    begin
      int k, bias;
      k = 0;
      bias = 8;
      for (int c = 0; c < 3000; c++) begin
        bit v, l;
        if (c % 400 == 0) bias = int'($urandom_range(0, 10));
        v = $urandom_range(0, 3) != 0;
        l = (((k % H_RES) == H_RES - 1) ^ ($urandom_range(0, 49) == 0));
        drive(v, rnd(), v && k == 0, l, int'($urandom_range(0, 9)) < bias);
        if (v) k = (k + 1) % (H_RES * 3);
      end
    end
    idle(DEPTH + 4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
